// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM state type and constants for the UART transmit arbiter
package uart_arb_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [7:0] NEWLINE = 8'h0A;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 frame serializer (ports: clock, reset, in_valid/in_ready/in_data handshake, busy, registered tx line)
module uart_tx_serializer
  import uart_arb_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       busy,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic tick;
  assign tick = cnt == CW'(CLKS_PER_BIT - 1);
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      tx <= 1'b1;
    end else begin
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      unique case (state)
        IDLE: if (in_valid) begin
          state <= START;
          sh <= in_data;
          tx <= 1'b0;
        end
        START: if (tick) begin
          state <= DATA;
          tx <= sh[0];
          sh <= sh >> 1;
          idx <= '0;
        end
        DATA: if (tick) begin
          idx <= idx + 1'b1;
          tx <= (idx == 3'd7) ? 1'b1 : sh[0];
          sh <= sh >> 1;
          if (idx == 3'd7) state <= STOP;
        end
        STOP: if (tick) state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin per-byte arbiter of NUM_REQ requesters onto one 8N1 UART tx line
// ports: clock, reset, io_req_valid/io_req_bits/io_req_ready per requester, io_uart_tx, io_busy, io_grant_id
// option: UART_ARB_LOCK_ON_NEWLINE_EN keeps the grant on one requester until it sends 8'h0A
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  localparam int IDW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   io_req_valid,
  input  logic [8*NUM_REQ-1:0] io_req_bits,
  output logic [NUM_REQ-1:0]   io_req_ready,
  output logic                 io_uart_tx,
  output logic                 io_busy,
  output logic [IDW-1:0]       io_grant_id
);
  logic [IDW-1:0] last, win, j;
  logic any, ser_ready, accept;
  logic [NUM_REQ-1:0] cand;
  logic [7:0] data;
`ifdef UART_ARB_LOCK_ON_NEWLINE_EN
  logic lock;
  assign cand = lock ? io_req_valid & (NUM_REQ'(1) << io_grant_id) : io_req_valid;
`else
  assign cand = io_req_valid;
`endif
  // scan offsets from far to near so the nearest valid requester after last wins
  always_comb begin
    win = last;
    any = 1'b0;
    j = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = IDW'((int'(last) + i) % NUM_REQ);
      if (cand[j]) begin
        win = j;
        any = 1'b1;
      end
    end
  end
  assign accept = ser_ready && any;
  assign io_req_ready = accept ? NUM_REQ'(1) << win : '0;
  assign data = io_req_bits[8*win +: 8];
  always_ff @(posedge clock) begin
    if (reset) begin
      last <= IDW'(NUM_REQ - 1);
      io_grant_id <= '0;
`ifdef UART_ARB_LOCK_ON_NEWLINE_EN
      lock <= 1'b0;
`endif
    end else if (accept) begin
      last <= win;
      io_grant_id <= win;
`ifdef UART_ARB_LOCK_ON_NEWLINE_EN
      lock <= data != NEWLINE;
`endif
    end
  end
  uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clock(clock),
    .reset(reset),
    .in_valid(any),
    .in_data(data),
    .in_ready(ser_ready),
    .busy(io_busy),
    .tx(io_uart_tx)
  );
endmodule
